zigzag_encoder: RTL and testbench

Protobuf ZigZag codec stage for the serializer datapath. It maps signed sint32/sint64 field values to unsigned varint-ready values (encode) and maps them back (decode). A 64-bit input word is transformed with 32- or 64-bit semantics selected per beat, and the result is registered with one cycle of latency. The stage sits between the field-value fetch and the varint packer.

---
 rtl/zigzag_pkg.sv | 38 +++
 rtl/zigzag_core.sv | 29 ++
 rtl/zigzag_encoder.sv | 40 ++++
 tb/tb_zigzag_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
// Shared constants, direction type and the four ZigZag transforms used by the
// serializer codec stage. Every function is pure bit manipulation on its argument.
package zigzag_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  typedef enum logic {
    ZZ_ENCODE = 1'b0,
    ZZ_DECODE = 1'b1
  } zz_dir_e;

  // sint64 -> uint64: shift left by one, flip every bit when the value is negative.
  function automatic logic [DATA_W-1:0] zz_enc64(input logic [DATA_W-1:0] n);
    return {n[DATA_W-2:0], 1'b0} ^ {DATA_W{n[DATA_W-1]}};
  endfunction

  // sint32 -> uint32, zero-extended to the full word so the varint packer sees a
  // non-negative 64-bit value.
  function automatic logic [DATA_W-1:0] zz_enc32(input logic [HALF_W-1:0] n);
    logic [HALF_W-1:0] r32;
    r32 = {n[HALF_W-2:0], 1'b0} ^ {HALF_W{n[HALF_W-1]}};
    return {{(DATA_W-HALF_W){1'b0}}, r32};
  endfunction

  // uint64 -> sint64: logical shift right by one, flip every bit when the LSB is set.
  function automatic logic [DATA_W-1:0] zz_dec64(input logic [DATA_W-1:0] u);
    return {1'b0, u[DATA_W-1:1]} ^ {DATA_W{u[0]}};
  endfunction

  // uint32 -> sint32, sign-extended so the recovered field reads correctly as int64.
  function automatic logic [DATA_W-1:0] zz_dec32(input logic [HALF_W-1:0] u);
    logic [HALF_W-1:0] r32;
    r32 = {1'b0, u[HALF_W-1:1]} ^ {HALF_W{u[0]}};
    return {{(DATA_W-HALF_W){r32[HALF_W-1]}}, r32};
  endfunction

endpackage

// File: rtl/zigzag_core.sv
// Combinational ZigZag transform: picks one of the four package functions from
// the direction and width selects. In 32-bit mode the upper operand half is
// never routed into the result.
module zigzag_core
  import zigzag_pkg::*;
(
  input  logic [DATA_W-1:0] in_val,
  input  logic              is_32,
  input  logic              decode,
  output logic [DATA_W-1:0] result
);

  zz_dir_e dir;

  assign dir = zz_dir_e'(decode);

  // Select the transform matching the requested direction and field width.
  always_comb begin
    result = '0;
    if (dir == ZZ_DECODE) begin
      if (is_32) result = zz_dec32(in_val[HALF_W-1:0]);
      else       result = zz_dec64(in_val);
    end else begin
      if (is_32) result = zz_enc32(in_val[HALF_W-1:0]);
      else       result = zz_enc64(in_val);
    end
  end

endmodule

// File: rtl/zigzag_encoder.sv
// ZigZag codec stage between field-value fetch and the varint packer.
// One-cycle latency, one result per cycle, no backpressure. The result register
// only loads on a consumed beat so out_val holds across idle cycles.
module zigzag_encoder #(
  parameter int DATA_W = 64   // only 64 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_val,
  input  logic              is_32,
  input  logic              decode,
  output logic [DATA_W-1:0] out_val,
  output logic              out_valid
);

  import zigzag_pkg::*;

  logic [DATA_W-1:0] result;

  zigzag_core u_core (
    .in_val (in_val),
    .is_32  (is_32),
    .decode (decode),
    .result (result)
  );

  // Capture the transformed value on a consumed beat; hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  out_val <= '0;
    else if (en) out_val <= result;
  end

  // One valid pulse per consumed beat; an in-flight beat is dropped by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= en;
  end

endmodule

// File: tb/tb_zigzag_encoder.sv
// Scoreboard bench for zigzag_encoder: the driver pushes hand-computed results
// into a queue as beats are issued; a negedge monitor pops and compares.
module tb_zigzag_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [63:0] in_val;
  logic        is_32;
  logic        decode;
  logic [63:0] out_val;
  logic        out_valid;

  typedef struct {
    logic [63:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic        en_seen;
  logic [63:0] last_exp = '0;

  zigzag_encoder #(.DATA_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_val    (in_val),
    .is_32     (is_32),
    .decode    (decode),
    .out_val   (out_val),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Bench record of whether a beat was consumed at the last rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_seen <= 1'b0;
    else        en_seen <= en;
  end

  // Monitor: valid must follow en by one cycle; pop on valid, else check hold.
  always @(negedge clk) begin
    sb_item_t it;
    if (rst_n) begin
      total++;
      if (out_valid !== en_seen) begin
        bad++;
        $display("FAIL valid_follow: out_valid=%b required=%b", out_valid, en_seen);
      end
      if (out_valid) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: out_val=%h with empty scoreboard", out_val);
        end else begin
          it = sb_q.pop_front();
          if (out_val !== it.exp) begin
            bad++;
            $display("FAIL %s: out_val=%h required=%h", it.name, out_val, it.exp);
          end else begin
            $display("beat %s: out_val=%h ok", it.name, out_val);
          end
          last_exp = it.exp;
        end
      end else begin
        total++;
        if (out_val !== last_exp) begin
          bad++;
          $display("FAIL hold: out_val=%h required=%h", out_val, last_exp);
        end
      end
    end
  end

  // Independent arithmetic model: non-negative x -> 2x, negative x -> -2x-1.
  function automatic logic [63:0] model_enc64(input logic [63:0] x);
    return x[63] ? ((~x) << 1) | 64'd1 : (x << 1);
  endfunction

  function automatic logic [31:0] model_enc32(input logic [31:0] x);
    return x[31] ? ((~x) << 1) | 32'd1 : (x << 1);
  endfunction

  task automatic beat(input logic e, input logic [63:0] v, input logic m32,
                      input logic dec, input logic [63:0] exp, input string nm);
    @(posedge clk); #1;
    en = e; in_val = v; is_32 = m32; decode = dec;
    if (e) sb_q.push_back('{exp: exp, name: nm});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic check_now(input string nm, input logic [63:0] v, input logic vl);
    total++;
    if (out_val !== v || out_valid !== vl) begin
      bad++;
      $display("FAIL %s: out_val=%h out_valid=%b required out_val=%h out_valid=%b",
               nm, out_val, out_valid, v, vl);
    end else begin
      $display("check %s: out_val=%h out_valid=%b ok", nm, out_val, out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64, e64;
    logic [31:0] r32, e32, up;

    // Reset held with en active: outputs must stay cleared.
    rst_n = 1'b0; en = 1'b1; in_val = 64'd5; is_32 = 1'b0; decode = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_now("reset_hold", 64'd0, 1'b0);
    end
    @(posedge clk); #1;
    en = 1'b0;
    rst_n = 1'b1;

    // Encode directed vectors.
    beat(1, 64'd2,                  1, 0, 64'h4,                  "enc32_pos2");
    beat(1, 64'd2,                  0, 0, 64'h4,                  "enc64_pos2");
    beat(1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 64'h3,                 "enc32_neg2");
    beat(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'h3,                 "enc64_neg2");
    beat(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h1,                 "enc64_neg1");
    beat(1, 64'd0,                  0, 0, 64'h0,                  "enc64_zero");
    beat(1, 64'd1,                  0, 0, 64'h2,                  "enc64_one");
    beat(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, "enc64_max");
    beat(1, 64'h8000_0000_0000_0000, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, "enc64_min");
    beat(1, 64'h0000_0000_7FFF_FFFF, 1, 0, 64'h0000_0000_FFFF_FFFE, "enc32_max");
    beat(1, 64'h1234_5678_8000_0000, 1, 0, 64'h0000_0000_FFFF_FFFF, "enc32_min_upper");

    // Decode directed vectors.
    beat(1, 64'h3,                  1, 1, 64'hFFFF_FFFF_FFFF_FFFE, "dec32_3");
    beat(1, 64'h4,                  0, 1, 64'h2,                  "dec64_4");
    beat(1, 64'h4,                  1, 1, 64'h2,                  "dec32_4");
    beat(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 64'h8000_0000_0000_0000, "dec64_allones");
    beat(1, 64'hDEAD_BEEF_0000_0001, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, "dec32_upper_ign");
    beat(1, 64'h0000_0000_FFFF_FFFE, 0, 1, 64'h0000_0000_7FFF_FFFF, "dec64_fffffffe");

    // Handshake: en = 1,0,1,1; mode changes during the idle cycle have no effect.
    beat(1, 64'd10, 0, 0, 64'd20, "hs_a");
    beat(0, 64'd99, 1, 1, 64'd0,  "hs_idle");
    beat(1, 64'd11, 0, 0, 64'd22, "hs_b");
    beat(1, 64'd12, 0, 0, 64'd24, "hs_c");

    // Mid-stream reset: the in-flight beat is dropped, outputs clear at once.
    @(posedge clk); #1;
    en = 1'b1; in_val = 64'd50; is_32 = 1'b0; decode = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_clear", 64'd0, 1'b0);
    sb_q.delete();
    last_exp = '0;
    en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_now("reset_mid_hold", 64'd0, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First beat after release behaves normally.
    beat(1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 64'h5, "post_reset_enc");

    // Round trips: encode then decode of the model's encoding returns the original.
    for (int i = 0; i < 6; i++) begin
      r64 = {$urandom(), $urandom()};
      e64 = model_enc64(r64);
      beat(1, r64, 0, 0, e64, $sformatf("rt64_enc_%0d", i));
      beat(1, e64, 0, 1, r64, $sformatf("rt64_dec_%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      r32 = $urandom();
      up  = $urandom();
      e32 = model_enc32(r32);
      beat(1, {up, r32}, 1, 0, {32'h0, e32}, $sformatf("rt32_enc_%0d", i));
      beat(1, {~up, e32}, 1, 1, {{32{r32[31]}}, r32}, $sformatf("rt32_dec_%0d", i));
    end

    idle();
    idle();
    @(negedge clk);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d beats never presented, required 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
